// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder sequencer:
//     - DEFAULT_WIDTH : default operand/sum width
//     - state_t       : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused)
//     - accepts_start : states in which a new start request is taken
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DONE   = 2'd2,
    ST_UNUSED = 2'd3
  } state_t;

  // A new addition may begin from IDLE, or from DONE for back-to-back issue.
  function automatic logic accepts_start(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// -----------------------------------------------------------------------------
// serial_fa_bit
//   Purely combinational 1-bit full adder, shared by every bit position of the
//   serial addition.
//   Ports:
//     a, b, cin : input bits
//     sum       : a ^ b ^ cin
//     cout      : majority(a, b, cin)
// -----------------------------------------------------------------------------
module serial_fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder sequencer. Computes {cout, sum} = a + b + cin one bit per
//   clock, LSB first, reusing a single full-adder cell WIDTH times.
//   Ports:
//     clk   : system clock, rising edge
//     rst   : synchronous active-high reset
//     start : begin an addition (honoured only in IDLE or DONE)
//     a, b  : WIDTH-bit operands, latched when start is accepted
//     cin   : carry-in, latched when start is accepted
//     busy  : high while the addition is running
//     done  : one-cycle pulse when sum/cout become valid
//     sum   : result, held from done until the next completed addition
//     cout  : final carry-out, same validity as sum
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q,     a_d;
  logic [WIDTH-1:0]   b_q,     b_d;
  logic [WIDTH-1:0]   res_q,   res_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;

  logic               fa_s;
  logic               fa_c;
  logic               last_bit;
  logic [WIDTH-1:0]   res_next;

  // The single shared cell always sees the current LSBs and running carry.
  serial_fa_bit u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  assign res_next = {fa_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && accepts_start(state_q)) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        carry_d = fa_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_next;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Publish the completed result directly so sum/cout are valid in
          // the same cycle done is high.
          state_d = ST_DONE;
          done_d  = 1'b1;
          sum_d   = res_next;
          cout_d  = fa_c;
        end else begin
          busy_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer. Adds two WIDTH-bit operands plus carry-in using a single 1-bit full-adder cell, one bit per clock, LSB first.
- Sits between a requester (start/done handshake) and the shared full-adder cell.
- Trades latency for area: one cell is reused WIDTH times instead of a WIDTH-cell ripple chain.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be at least 2).
- CNT_W, $clog2(WIDTH), width of the bit-index counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result bits; valid from the done cycle until the next accepted start.
- cout  output  1  final carry-out; same validity as sum.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0; counter, carry and operand registers are cleared.
  - Reset overrides everything, including mid-RUN; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch a, b and cin (carry register <= cin), counter <= 0, go to RUN.
  - start=0 -> stay in IDLE; outputs hold.
- RUN, each cycle:
  - The cell computes s and c from a_reg[0], b_reg[0] and the carry register.
  - Carry register <= c.
  - a_reg and b_reg shift right by 1.
  - Result shift register <= {s, result[WIDTH-1:1]}.
  - Counter increments.
  - When counter == WIDTH-1 the last bit is processed in that cycle, and the state goes to DONE.
  - start is ignored while in RUN.
- DONE (exactly one cycle):
  - done=1; sum = result register; cout = carry register.
  - start=1 in this cycle is accepted (back-to-back): operands are latched and the state goes to RUN.
  - Otherwise the state goes to IDLE.
- Latency: start sampled at edge N -> RUN occupies edges N+1..N+WIDTH -> done is high in the cycle following edge N+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles when start is held high.
- Output stability:
  - busy = (state == RUN).
  - sum and cout are registered and hold their last result through IDLE.
  - sum and cout update only at DONE entry; they are not cleared on start.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Input changes: changes on a, b or cin after acceptance have no effect on the result in flight.

Decomposition:
- Shared include file holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default WIDTH.
- One sub-module, serial_fa_bit:
  - Purely combinational 1-bit full adder (a, b, cin -> sum, cout).
  - Instantiated once and driven by the FSM datapath.
- Unused state encoding 2'd3 recovers to IDLE.

Test Plan:
- Reset, then a=8'h00, b=8'h00, cin=0, start pulse -> busy for 8 cycles; done pulse; sum=8'h00, cout=0.
- a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0; done exactly 9 cycles after the start edge.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Full carry propagation.
- Busy-ignore and input isolation:
  - Start a=8'h10, b=8'h01; during RUN pulse start with a=8'hFF, b=8'hFF.
  - Change a and b mid-RUN.
  - Expect sum=8'h11, cout=0, and exactly one done.
- Reset and back-to-back:
  - Assert rst at the 4th RUN cycle -> next cycle IDLE, busy=0, sum=0, cout=0, no done.
  - Hold start=1 with 8'h01+8'h01 then 8'h02+8'h02 -> done pulses 9 cycles apart with sum=8'h02, then sum=8'h04.
